// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder.
// Accepts one load/store, waits WAIT_CYCLES, then holds the response until the
// initiator takes it. Misaligned or out-of-range accesses return an error and
// never touch storage.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AddrW = $clog2(DEPTH_WORDS);
    // Counter reload; the guard keeps WAIT_CYCLES = 0 from underflowing.
    localparam logic [3:0] WaitLoad = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    // Captured request fields
    logic        write_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;

    // Fields of the transaction in flight
    logic             cur_write;
    logic [31:0]      cur_addr;
    logic [31:0]      cur_wdata;
    logic [3:0]       cur_be;
    logic             cur_err;
    logic [AddrW-1:0] cur_idx;

    logic accept;
    logic enter_resp;
    logic commit_wr;

    logic [31:0] mem [DEPTH_WORDS];

    assign req_ready = (state_q == StIdle) && !rst;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // In IDLE the live inputs are the transaction (they are captured this edge),
    // which lets a zero-wait access enter RESP on the accepting edge.
    always_comb begin
        if (state_q == StIdle) begin
            cur_write = req_write;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
            cur_be    = req_be;
        end else begin
            cur_write = write_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_be    = be_q;
        end
        cur_idx = cur_addr[AddrW+1:2];
        cur_err = (cur_addr[1:0] != 2'b00) || (cur_addr[31:AddrW+2] != '0);
    end

    // Next-state, wait counter and response data
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        enter_resp = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        enter_resp = 1'b1;
                        state_d    = StResp;
                    end else begin
                        cnt_d   = WaitLoad;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    enter_resp = 1'b1;
                    state_d    = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
        if (enter_resp) begin
            err_d   = cur_err;
            rdata_d = (cur_err || cur_write) ? 32'd0 : mem[cur_idx];
        end
    end

    // Reset gates the commit so an abandoned store never lands.
    assign commit_wr = enter_resp && cur_write && !cur_err && !rst;

    // Control state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Request capture on accept
    always_ff @(posedge clk) begin
        if (accept) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end
    end

    // Storage byte writes; contents are deliberately not reset
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (commit_wr && cur_be[b]) begin
                mem[cur_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
            end
        end
    end

endmodule
